// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core.
// Holds the next-PC select codes (also used by the hazard and control units),
// the fetch FSM state type, the default bubble word and the IF/ID payload type.
package cpu_pkg;

  // Next-PC select codes; 1xx is reserved and treated as sequential.
  localparam logic [2:0] PC_SRC_SEQ    = 3'b000;
  localparam logic [2:0] PC_SRC_BRANCH = 3'b001;
  localparam logic [2:0] PC_SRC_JUMP   = 3'b010;
  localparam logic [2:0] PC_SRC_JR     = 3'b011;

  // Word inserted into the pipeline as a bubble.
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding for PC_F
    HOLD  = 2'd1,  // fetched word parked in the skid buffer
    DROP  = 2'd2   // stale request outstanding, response will be discarded
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
  } if_id_t;

  function automatic logic isRedirect(input logic [2:0] pcSrc);
    return (pcSrc == PC_SRC_BRANCH) || (pcSrc == PC_SRC_JUMP) || (pcSrc == PC_SRC_JR);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register with flush > stall > load > bubble priority.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   synchronous active-low reset, loads ClearVal
//   stall_i  hold current contents
//   flush_i  load ClearVal (wins over stall)
//   load_i   capture data_i
//   data_i   next contents when loading
//   data_o   registered contents
// With neither stall nor load the register falls back to ClearVal (a bubble).
module if_id_reg #(
  parameter int unsigned      Width    = 97,
  parameter logic [Width-1:0] ClearVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] data_q, data_d;

  always_comb begin
    data_d = ClearVal;
    if (flush_i) begin
      data_d = ClearVal;
    end else if (stall_i) begin
      data_d = data_q;
    end else if (load_i) begin
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= ClearVal;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a req/ack handshake to a
// variable-latency instruction memory, parks a fetched word while the front
// end is stalled and discards in-flight fetches on a control-flow redirect.
// Ports:
//   CLK, RST_N                      clock, synchronous active-low reset
//   Stall_F, Stall_D, Flush_D       hazard-unit controls
//   PC_Src_S                        next-PC select (seq/branch/jump/jr)
//   Branch_Target, Jump_Target,
//   JR_Target                       redirect targets
//   IMem_Req, IMem_Addr             fetch request (held stable until ack)
//   IMem_Ack, IMem_Rdata            one-cycle response strobe and data
//   Instr_D, PC_D, PCPlus4_D,
//   Valid_D                         IF/ID register contents
//   Fetch_Wait                      stage waiting on memory
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Stall_F,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic [2:0]  PC_Src_S,
  input  logic [31:0] Branch_Target,
  input  logic [31:0] Jump_Target,
  input  logic [31:0] JR_Target,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Rdata,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D,
  output logic        Fetch_Wait
);

  localparam int unsigned IfIdWidth = $bits(if_id_t);

  fetch_state_t state_q, state_d;
  logic [31:0]  pcF_q, pcF_d;
  logic [31:0]  dropAddr_q, dropAddr_d;
  logic [31:0]  bufInstr_q, bufInstr_d;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pcPlus4F;
  logic         loadIfId;
  logic [31:0]  loadInstr;
  if_id_t       ifIdIn, ifIdOut;

  assign redirect = isRedirect(PC_Src_S);
  assign pcPlus4F = pcF_q + 32'd4;

  always_comb begin
    target = pcPlus4F;
    case (PC_Src_S)
      PC_SRC_BRANCH: target = Branch_Target;
      PC_SRC_JUMP:   target = Jump_Target;
      PC_SRC_JR:     target = JR_Target;
      default:       target = pcPlus4F;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pcF_d      = pcF_q;
    dropAddr_d = dropAddr_q;
    bufInstr_d = bufInstr_q;
    loadIfId   = 1'b0;
    loadInstr  = bufInstr_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          // Redirect wins over Stall_F; an unanswered request must still be
          // seen through at its original address.
          pcF_d = target;
          if (!IMem_Ack) begin
            state_d    = DROP;
            dropAddr_d = pcF_q;
          end
        end else if (IMem_Ack) begin
          if (!Stall_F) begin
            loadIfId  = 1'b1;
            loadInstr = IMem_Rdata;
            pcF_d     = pcPlus4F;
          end else begin
            bufInstr_d = IMem_Rdata;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pcF_d   = target;
          state_d = FETCH;
        end else if (!Stall_F) begin
          // PC_F still names the buffered word, so it goes out with it.
          loadIfId = 1'b1;
          pcF_d    = pcPlus4F;
          state_d  = FETCH;
        end
      end
      DROP: begin
        if (redirect) begin
          pcF_d = target;
        end
        if (IMem_Ack) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= FETCH;
      pcF_q      <= RESET_PC;
      dropAddr_q <= RESET_PC;
      bufInstr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pcF_q      <= pcF_d;
      dropAddr_q <= dropAddr_d;
      bufInstr_q <= bufInstr_d;
    end
  end

  // Request is gated by reset so an in-flight fetch is abandoned immediately.
  assign IMem_Req   = RST_N && (state_q != HOLD);
  assign IMem_Addr  = (state_q == DROP) ? dropAddr_q : pcF_q;
  assign Fetch_Wait = ((state_q == FETCH) && !IMem_Ack) || (state_q == DROP);

  assign ifIdIn.valid   = 1'b1;
  assign ifIdIn.instr   = loadInstr;
  assign ifIdIn.pc      = pcF_q;
  assign ifIdIn.pcPlus4 = pcPlus4F;

  if_id_reg #(
    .Width   (IfIdWidth),
    .ClearVal({1'b0, NOP_INSTR, 64'h0})
  ) u_if_id (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .stall_i(Stall_D),
    .flush_i(Flush_D),
    .load_i (loadIfId),
    .data_i (ifIdIn),
    .data_o (ifIdOut)
  );

  assign Instr_D   = ifIdOut.instr;
  assign PC_D      = ifIdOut.pc;
  assign PCPlus4_D = ifIdOut.pcPlus4;
  assign Valid_D   = ifIdOut.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Stall_F, Stall_D, Flush_D;
  logic [2:0]  PC_Src_S;
  logic [31:0] Branch_Target, Jump_Target, JR_Target;
  logic        IMem_Req, IMem_Ack;
  logic [31:0] IMem_Addr, IMem_Rdata;
  logic [31:0] Instr_D, PC_D, PCPlus4_D;
  logic        Valid_D, Fetch_Wait;

  // Second instance: reset vector at the top of memory, zero-wait memory.
  logic        r2Req, r2Valid, r2Wait;
  logic [31:0] r2Addr, r2Instr, r2Pc, r2Pc4;

  int nTests = 0;
  int nFails = 0;

  // Memory model: fixLat >= 0 forces the ack delay, -1 draws it randomly.
  int fixLat = 0;
  int curLat = 0;
  int waitCnt = 0;
  int latNow;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_0011;
  endfunction

  always #5 CLK = ~CLK;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D),
    .PC_Src_S(PC_Src_S), .Branch_Target(Branch_Target), .Jump_Target(Jump_Target),
    .JR_Target(JR_Target), .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
    .IMem_Ack(IMem_Ack), .IMem_Rdata(IMem_Rdata), .Instr_D(Instr_D), .PC_D(PC_D),
    .PCPlus4_D(PCPlus4_D), .Valid_D(Valid_D), .Fetch_Wait(Fetch_Wait)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .CLK(CLK), .RST_N(RST_N), .Stall_F(1'b0), .Stall_D(1'b0), .Flush_D(1'b0),
    .PC_Src_S(3'b000), .Branch_Target(32'h0), .Jump_Target(32'h0), .JR_Target(32'h0),
    .IMem_Req(r2Req), .IMem_Addr(r2Addr), .IMem_Ack(r2Req), .IMem_Rdata(memWord(r2Addr)),
    .Instr_D(r2Instr), .PC_D(r2Pc), .PCPlus4_D(r2Pc4), .Valid_D(r2Valid),
    .Fetch_Wait(r2Wait)
  );

  always_comb latNow = (fixLat >= 0) ? fixLat : curLat;
  assign IMem_Ack   = IMem_Req && (waitCnt >= latNow);
  assign IMem_Rdata = IMem_Ack ? memWord(IMem_Addr) : 32'hDEAD_BEEF;

  always @(posedge CLK) begin
    if (!RST_N || !IMem_Req || IMem_Ack) begin
      waitCnt <= 0;
      curLat  <= int'($urandom_range(0, 3));
    end else begin
      waitCnt <= waitCnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    assert (got === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Handshake monitor: an unanswered request must reappear unchanged.
  logic        pendPrev = 1'b0;
  logic [31:0] pendAddr = 32'h0;
  always @(negedge CLK) begin
    if (pendPrev && RST_N) begin
      chk("hs_req_stable", {31'h0, IMem_Req}, 32'd1);
      chk("hs_addr_stable", IMem_Addr, pendAddr);
    end
    pendPrev <= RST_N && IMem_Req && !IMem_Ack;
    pendAddr <= IMem_Addr;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] expNext, tgt, svInstr, svPc;
  logic        svValid, redir, stall;
  int          nDeliv, r;
  logic        got;

  initial begin
    RST_N = 1'b0; Stall_F = 1'b0; Stall_D = 1'b0; Flush_D = 1'b0;
    PC_Src_S = PC_SRC_SEQ; Branch_Target = 32'h0; Jump_Target = 32'h0; JR_Target = 32'h0;

    // Reset state
    cyc(); cyc(); settle();
    chk("rst_instr", Instr_D, DEFAULT_NOP_INSTR);
    chk("rst_pc", PC_D, 32'h0);
    chk("rst_pc4", PCPlus4_D, 32'h0);
    chk("rst_valid", {31'h0, Valid_D}, 32'd0);
    chk("rst_req_gated", {31'h0, IMem_Req}, 32'd0);
    chk("rst_req_gated2", {31'h0, r2Req}, 32'd0);

    // Zero-wait streaming from PC 0
    cyc(); RST_N = 1'b1; settle();
    chk("c0_req", {31'h0, IMem_Req}, 32'd1);
    chk("c0_addr", IMem_Addr, 32'h0);
    chk("c0_wait", {31'h0, Fetch_Wait}, 32'd0);
    chk("wrap_addr0", r2Addr, 32'hFFFF_FFFC);
    cyc(); settle();
    chk("c1_instr", Instr_D, memWord(32'h0));
    chk("c1_pc", PC_D, 32'h0);
    chk("c1_pc4", PCPlus4_D, 32'h4);
    chk("c1_valid", {31'h0, Valid_D}, 32'd1);
    chk("c1_addr", IMem_Addr, 32'h4);
    chk("wrap_instr", r2Instr, memWord(32'hFFFF_FFFC));
    chk("wrap_pc4", r2Pc4, 32'h0);
    chk("wrap_valid", {31'h0, r2Valid}, 32'd1);
    chk("wrap_wait", {31'h0, r2Wait}, 32'd0);
    chk("wrap_addr1", r2Addr, 32'h0);

    // Stall front end at the ack of 0x8
    cyc(); Stall_F = 1'b1; Stall_D = 1'b1; settle();
    chk("c2_instr", Instr_D, memWord(32'h4));
    chk("c2_pc", PC_D, 32'h4);
    chk("c2_addr", IMem_Addr, 32'h8);
    chk("wrap_instr2", r2Instr, memWord(32'h0));
    chk("wrap_pc2", r2Pc, 32'h0);
    cyc(); settle();
    chk("hold_noreq", {31'h0, IMem_Req}, 32'd0);
    chk("hold_nowait", {31'h0, Fetch_Wait}, 32'd0);
    chk("hold_instr", Instr_D, memWord(32'h4));
    chk("hold_valid", {31'h0, Valid_D}, 32'd1);
    cyc(); settle();
    chk("hold_instr2", Instr_D, memWord(32'h4));
    chk("hold_noreq2", {31'h0, IMem_Req}, 32'd0);
    cyc(); Stall_F = 1'b0; Stall_D = 1'b0; settle();
    chk("release_noreq", {31'h0, IMem_Req}, 32'd0);

    // Buffered word released, then a 3-cycle fetch of 0xC
    cyc(); fixLat = 2; settle();
    chk("buf_instr", Instr_D, memWord(32'h8));
    chk("buf_pc", PC_D, 32'h8);
    chk("lat_addr0", IMem_Addr, 32'hC);
    chk("lat_wait0", {31'h0, Fetch_Wait}, 32'd1);
    cyc(); settle();
    chk("lat_addr1", IMem_Addr, 32'hC);
    chk("lat_wait1", {31'h0, Fetch_Wait}, 32'd1);
    chk("lat_bubble1", {31'h0, Valid_D}, 32'd0);
    cyc(); settle();
    chk("lat_addr2", IMem_Addr, 32'hC);
    chk("lat_wait2", {31'h0, Fetch_Wait}, 32'd0);
    chk("lat_bubble2", {31'h0, Valid_D}, 32'd0);

    // Branch to 0x40 while 0x10 is pending, then re-redirect to 0x80 in DROP
    cyc(); PC_Src_S = PC_SRC_BRANCH; Branch_Target = 32'h40; Flush_D = 1'b1; settle();
    chk("lat_instr", Instr_D, memWord(32'hC));
    chk("lat_valid", {31'h0, Valid_D}, 32'd1);
    chk("br_addr", IMem_Addr, 32'h10);
    cyc(); Branch_Target = 32'h80; settle();
    chk("drop_addr", IMem_Addr, 32'h10);
    chk("drop_req", {31'h0, IMem_Req}, 32'd1);
    chk("drop_wait", {31'h0, Fetch_Wait}, 32'd1);
    chk("drop_flush", {31'h0, Valid_D}, 32'd0);
    cyc(); PC_Src_S = PC_SRC_SEQ; Flush_D = 1'b0; settle();
    chk("drop_addr_ack", IMem_Addr, 32'h10);
    chk("drop_wait_ack", {31'h0, Fetch_Wait}, 32'd1);
    cyc(); fixLat = 0; settle();
    chk("redir_addr", IMem_Addr, 32'h80);
    chk("redir_bubble", {31'h0, Valid_D}, 32'd0);
    chk("redir_wait", {31'h0, Fetch_Wait}, 32'd0);

    // Jump while stalled in HOLD
    cyc(); Stall_F = 1'b1; Stall_D = 1'b1; settle();
    chk("t80_instr", Instr_D, memWord(32'h80));
    chk("t80_pc4", PCPlus4_D, 32'h84);
    chk("t80_addr", IMem_Addr, 32'h84);
    cyc(); Stall_D = 1'b0; Flush_D = 1'b1; PC_Src_S = PC_SRC_JUMP; Jump_Target = 32'h100;
    settle();
    chk("jmp_hold_noreq", {31'h0, IMem_Req}, 32'd0);
    chk("jmp_hold_instr", Instr_D, memWord(32'h80));
    cyc(); Stall_F = 1'b0; Flush_D = 1'b0; PC_Src_S = PC_SRC_SEQ; settle();
    chk("jmp_addr", IMem_Addr, 32'h100);
    chk("jmp_bubble", {31'h0, Valid_D}, 32'd0);

    // JR with concurrent ack and stall, to the top of memory
    cyc(); PC_Src_S = PC_SRC_JR; JR_Target = 32'hFFFF_FFFC; Stall_F = 1'b1; Flush_D = 1'b1;
    settle();
    chk("t100_instr", Instr_D, memWord(32'h100));
    cyc(); PC_Src_S = PC_SRC_SEQ; Stall_F = 1'b0; Flush_D = 1'b0; settle();
    chk("jr_addr", IMem_Addr, 32'hFFFF_FFFC);
    chk("jr_bubble", {31'h0, Valid_D}, 32'd0);

    // Wrap, and reserved select codes act as sequential
    cyc(); PC_Src_S = 3'b101; Branch_Target = 32'h200; Jump_Target = 32'h300;
    JR_Target = 32'h400; settle();
    chk("top_instr", Instr_D, memWord(32'hFFFF_FFFC));
    chk("top_pc4", PCPlus4_D, 32'h0);
    chk("wrap_next_addr", IMem_Addr, 32'h0);
    cyc(); PC_Src_S = 3'b111; settle();
    chk("rsv_instr", Instr_D, memWord(32'h0));
    chk("rsv_addr", IMem_Addr, 32'h4);
    cyc(); PC_Src_S = PC_SRC_SEQ; fixLat = 3; settle();
    chk("rsv_instr2", Instr_D, memWord(32'h4));
    chk("pend_addr", IMem_Addr, 32'h8);
    chk("pend_wait", {31'h0, Fetch_Wait}, 32'd1);

    // Reset mid-request
    cyc(); RST_N = 1'b0; settle();
    chk("midrst_req", {31'h0, IMem_Req}, 32'd0);
    cyc(); RST_N = 1'b1; fixLat = 0; settle();
    chk("restart_addr", IMem_Addr, 32'h0);
    chk("restart_req", {31'h0, IMem_Req}, 32'd1);
    chk("restart_valid", {31'h0, Valid_D}, 32'd0);
    cyc(); settle();
    chk("restart_instr", Instr_D, memWord(32'h0));
    chk("restart_pc", PC_D, 32'h0);

    // Random phase: in-order delivery scoreboard
    expNext = 32'h4;
    nDeliv = 0;
    svInstr = Instr_D; svPc = PC_D; svValid = Valid_D;
    fixLat = -1;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 15));
      stall = ($urandom_range(0, 3) == 0);
      Branch_Target = $urandom();
      Jump_Target = $urandom();
      JR_Target = $urandom();
      redir = 1'b1;
      case (r)
        0: begin PC_Src_S = PC_SRC_BRANCH; tgt = Branch_Target; end
        1: begin PC_Src_S = PC_SRC_JUMP; tgt = Jump_Target; end
        2: begin PC_Src_S = PC_SRC_JR; tgt = JR_Target; end
        3: begin PC_Src_S = 3'($urandom_range(4, 7)); redir = 1'b0; tgt = 32'h0; end
        default: begin PC_Src_S = PC_SRC_SEQ; redir = 1'b0; tgt = 32'h0; end
      endcase
      Flush_D = redir;
      Stall_F = stall;
      Stall_D = stall;
      cyc(); settle();
      if (redir) begin
        chk("rnd_flush_valid", {31'h0, Valid_D}, 32'd0);
        expNext = tgt;
      end else if (stall) begin
        chk("rnd_hold_instr", Instr_D, svInstr);
        chk("rnd_hold_pc", PC_D, svPc);
        chk("rnd_hold_valid", {31'h0, Valid_D}, {31'h0, svValid});
      end else if (Valid_D) begin
        chk("rnd_pc", PC_D, expNext);
        chk("rnd_instr", Instr_D, memWord(PC_D));
        chk("rnd_pc4", PCPlus4_D, PC_D + 32'd4);
        expNext = expNext + 32'd4;
        nDeliv++;
      end
      svInstr = Instr_D; svPc = PC_D; svValid = Valid_D;
    end

    // Drain: a delivery must follow within a bounded number of cycles
    Stall_F = 1'b0; Stall_D = 1'b0; Flush_D = 1'b0; PC_Src_S = PC_SRC_SEQ; fixLat = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cyc(); settle();
      if (Valid_D) got = 1'b1;
    end
    chk("drain_delivery", {31'h0, got}, 32'd1);
    chk("drain_pc", PC_D, expNext);
    chk("rnd_progress", {31'h0, (nDeliv > 300)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
